subleq_seq: RTL and testbench

SUBLEQ_SEQ -- requirements
Module: subleq_seq

---
 rtl/subleq_seq_pkg.sv | 18 +
 rtl/subleq_seq.sv | 149 ++++++++++++++
 tb/tb_subleq_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_seq_pkg.sv
// ============================================================================
// Module      : subleq_seq_pkg
// Description : Shared word type and halt-address default for the SUBLEQ core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package subleq_seq_pkg;

   localparam int c_W = 8;

   typedef logic [c_W-1:0] word_t;

   localparam word_t c_HALT_ADDR = '1;

endpackage : subleq_seq_pkg

`default_nettype wire

// File: rtl/subleq_seq.sv
// ============================================================================
// Module      : subleq_seq
// Description : Seven-cycle SUBLEQ sequencer driving a synchronous RAM and an
//               external subtract/branch ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subleq_seq
   import subleq_seq_pkg::*;
#(
   parameter int             W         = c_W,
   parameter logic [W-1:0]   HALT_ADDR = c_HALT_ADDR
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         run,
   output logic [W-1:0] mem_addr,
   input  logic [W-1:0] mem_rdata,
   output logic [W-1:0] mem_wdata,
   output logic         mem_we,
   output logic [W-1:0] reg_1,
   output logic [W-1:0] reg_2,
   input  logic [W-1:0] result,
   input  logic         branch,
   output logic [W-1:0] pc,
   output logic         instr_done,
   output logic         halted
);

   typedef enum logic [2:0] {
      S_IA   = 3'd0,
      S_IB   = 3'd1,
      S_IC   = 3'd2,
      S_RA   = 3'd3,
      S_RB   = 3'd4,
      S_LB   = 3'd5,
      S_EX   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   localparam logic [W-1:0] c_ONE   = W'(1);
   localparam logic [W-1:0] c_TWO   = W'(2);
   localparam logic [W-1:0] c_THREE = W'(3);

   state_t       r_state;
   logic [W-1:0] r_pc;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic [W-1:0] r_c;
   logic [W-1:0] r_va;
   logic [W-1:0] r_vb;
   logic [W-1:0] r_mem_addr;
   logic         r_we;
   logic         r_done;
   logic         r_halted;

   // mem_addr is loaded with the address belonging to the state being entered,
   // so the RAM always sees the right address during that state.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         r_state    <= S_IA;
         r_pc       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_c        <= '0;
         r_va       <= '0;
         r_vb       <= '0;
         r_mem_addr <= '0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IA: begin
               if (run) begin
                  r_state    <= S_IB;
                  r_mem_addr <= r_pc + c_ONE;
               end else begin
                  r_mem_addr <= r_pc;
               end
            end
            S_IB: begin
               r_a        <= mem_rdata;
               r_mem_addr <= r_pc + c_TWO;
               r_state    <= S_IC;
            end
            S_IC: begin
               r_b        <= mem_rdata;
               r_mem_addr <= r_a;
               r_state    <= S_RA;
            end
            S_RA: begin
               r_c        <= mem_rdata;
               r_mem_addr <= r_b;
               r_state    <= S_RB;
            end
            S_RB: begin
               r_va    <= mem_rdata;
               r_state <= S_LB;
            end
            S_LB: begin
               r_vb       <= mem_rdata;
               r_mem_addr <= r_b;
               r_we       <= 1'b1;
               r_done     <= 1'b1;
               r_state    <= S_EX;
            end
            S_EX: begin
               if (branch) begin
                  r_pc       <= r_c;
                  r_mem_addr <= r_c;
                  if (r_c == HALT_ADDR) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end else begin
                     r_state  <= S_IA;
                  end
               end else begin
                  r_pc       <= r_pc + c_THREE;
                  r_mem_addr <= r_pc + c_THREE;
                  r_state    <= S_IA;
               end
            end
            S_HALT: begin
               r_mem_addr <= r_pc;
            end
            default: begin
               r_state <= S_IA;
            end
         endcase
      end
   end

   // Reset asserted during EX must suppress the write at that same edge.
   assign mem_we     = r_we & n_reset;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = result;
   assign reg_1      = r_va;
   assign reg_2      = r_vb;
   assign pc         = r_pc;
   assign instr_done = r_done;
   assign halted     = r_halted;

endmodule : subleq_seq

`default_nettype wire

// File: tb/tb_subleq_seq.sv
// ============================================================================
// Module      : tb_subleq_seq
// Description : Self-checking bench for subleq_seq with RAM, ALU and an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subleq_seq;

   logic       clk;
   logic       n_reset;
   logic       run;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] reg_1;
   logic [7:0] reg_2;
   logic [7:0] result;
   logic       branch;
   logic [7:0] pc;
   logic       instr_done;
   logic       halted;

   logic [7:0] mem     [256];
   logic [7:0] img     [256];
   logic [7:0] ref_mem [256];
   logic       load_go;
   logic [7:0] ref_pc;
   int         total;
   int         bad;

   subleq_seq dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .run        (run),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .reg_1      (reg_1),
      .reg_2      (reg_2),
      .result     (result),
      .branch     (branch),
      .pc         (pc),
      .instr_done (instr_done),
      .halted     (halted)
   );

   assign result = reg_2 - reg_1;
   assign branch = (result == 8'd0) || result[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_go) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Holds the core in reset while the RAM image is copied in.
   task automatic load_and_reset();
      n_reset = 1'b0;
      run     = 1'b0;
      load_go = 1'b1;
      step();
      load_go = 1'b0;
      step();
      n_reset = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
      ref_pc = 8'd0;
   endtask

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 8'd0;
   endtask

   // Runs one instruction on the DUT and compares against the model.
   task automatic exec_check(input string name, output bit hlt);
      logic [7:0] a, b, c, va, vb, r, npc;
      logic [7:0] fa [3];
      logic       tk;
      int         cyc;
      bit         seen;
      a   = ref_mem[ref_pc];
      b   = ref_mem[ref_pc + 8'd1];
      c   = ref_mem[ref_pc + 8'd2];
      va  = ref_mem[a];
      vb  = ref_mem[b];
      r   = vb - va;
      tk  = ($signed(r) <= 0);
      npc = tk ? c : ref_pc + 8'd3;
      hlt = tk && (c == 8'hFF);
      ref_mem[b] = r;
      for (int i = 0; i < 3; i++) fa[i] = 8'hxx;
      cyc  = 0;
      seen = 0;
      while (cyc < 20 && !seen) begin
         if (cyc < 3) fa[cyc] = mem_addr;
         if (instr_done === 1'b1) seen = 1;
         else begin
            step();
            cyc++;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s timeout: instr_done never seen within 20 cycles", name);
         return;
      end
      total++;
      if (cyc !== 6) begin
         bad++;
         $display("FAIL %s latency: got cycle %0d expected 6", name, cyc);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (fa[i] !== ref_pc + 8'(i)) begin
            bad++;
            $display("FAIL %s fetch%0d: got %h expected %h", name, i, fa[i], ref_pc + 8'(i));
         end
      end
      total++;
      if (mem_we !== 1'b1 || mem_addr !== b || mem_wdata !== r) begin
         bad++;
         $display("FAIL %s write: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                  name, mem_we, mem_addr, mem_wdata, b, r);
      end
      total++;
      if (reg_1 !== va || reg_2 !== vb || branch !== tk) begin
         bad++;
         $display("FAIL %s operands: got reg_1=%h reg_2=%h branch=%b expected %h %h %b",
                  name, reg_1, reg_2, branch, va, vb, tk);
      end
      step();
      total++;
      if (pc !== npc || halted !== hlt || instr_done !== 1'b0) begin
         bad++;
         $display("FAIL %s next: got pc=%h halted=%b done=%b expected pc=%h halted=%b done=0",
                  name, pc, halted, instr_done, npc, hlt);
      end
      total++;
      if (mem[b] !== r) begin
         bad++;
         $display("FAIL %s ram: got mem[%h]=%h expected %h", name, b, mem[b], r);
      end
      ref_pc = npc;
   endtask

   task automatic test_reset();
      clear_img();
      load_and_reset();
      total++;
      if (pc !== 8'd0 || halted !== 1'b0 || mem_we !== 1'b0 || instr_done !== 1'b0 ||
          reg_1 !== 8'd0 || reg_2 !== 8'd0 || mem_addr !== 8'd0) begin
         bad++;
         $display("FAIL reset: got pc=%h halted=%b we=%b done=%b r1=%h r2=%h addr=%h expected all zero",
                  pc, halted, mem_we, instr_done, reg_1, reg_2, mem_addr);
      end
   endtask

   task automatic test_basic();
      bit h;
      clear_img();
      img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'd20;
      img[9] = 8'd5; img[10] = 8'd3;
      load_and_reset();
      run = 1'b1;
      exec_check("taken_neg", h);
      clear_img();
      img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'd20;
      img[9] = 8'd2; img[10] = 8'd7;
      load_and_reset();
      run = 1'b1;
      exec_check("not_taken", h);
      clear_img();
      img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'd40;
      img[9] = 8'h80; img[10] = 8'h00;
      load_and_reset();
      run = 1'b1;
      exec_check("min_neg", h);
   endtask

   task automatic test_halt();
      bit h;
      bit ok;
      clear_img();
      img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'hFF;
      img[9] = 8'd5; img[10] = 8'd3;
      load_and_reset();
      run = 1'b1;
      exec_check("halt_instr", h);
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         run = 1'($urandom_range(0, 1));
         if (mem_we !== 1'b0 || halted !== 1'b1 || pc !== 8'hFF || mem_addr !== 8'hFF) ok = 0;
         step();
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL halt_hold: got we=%b halted=%b pc=%h addr=%h expected 0 1 ff ff",
                  mem_we, halted, pc, mem_addr);
      end
   endtask

   task automatic test_wrap();
      bit h;
      clear_img();
      img[0] = 8'h30; img[1] = 8'h30; img[2] = 8'hFE;
      img[8'h30] = 8'h11;
      img[8'hFE] = 8'h40; img[8'hFF] = 8'h41;
      img[8'h40] = 8'd1;  img[8'h41] = 8'd5;
      load_and_reset();
      run = 1'b1;
      exec_check("same_ab", h);
      exec_check("wrap_fetch", h);
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_img();
      img[0] = 8'd9; img[1] = 8'd10; img[2] = 8'd20;
      img[9] = 8'd5; img[10] = 8'd3;
      load_and_reset();
      run = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_reset = 1'b0;
      run     = 1'b0;
      step();
      n_reset = 1'b1;
      ok = 1;
      for (int i = 0; i < 20; i++) begin
         if (mem_we !== 1'b0 || pc !== 8'd0 || mem_addr !== 8'd0 || instr_done !== 1'b0) ok = 0;
         step();
      end
      total++;
      if (!ok || mem[10] !== 8'd3) begin
         bad++;
         $display("FAIL reset_rb: got we=%b pc=%h addr=%h mem10=%h expected 0 00 00 03",
                  mem_we, pc, mem_addr, mem[10]);
      end
      run = 1'b1;
      for (int i = 0; i < 6; i++) step();
      total++;
      if (instr_done !== 1'b1) begin
         bad++;
         $display("FAIL reset_ex_reach: got done=%b expected 1", instr_done);
      end
      n_reset = 1'b0;
      run     = 1'b0;
      step();
      n_reset = 1'b1;
      step();
      total++;
      if (mem[10] !== 8'd3 || pc !== 8'd0) begin
         bad++;
         $display("FAIL reset_ex: got mem10=%h pc=%h expected 03 00", mem[10], pc);
      end
   endtask

   task automatic test_random();
      bit h;
      int mism;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
         load_and_reset();
         run = 1'b1;
         h = 0;
         for (int k = 0; k < 40 && !h; k++) exec_check("random", h);
         mism = 0;
         for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
         total++;
         if (mism != 0) begin
            bad++;
            $display("FAIL random_ram: got %0d differing words expected 0", mism);
         end
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      n_reset = 1'b0;
      run     = 1'b0;
      load_go = 1'b0;
      ref_pc  = 8'd0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_halt();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_subleq_seq

`default_nettype wire
